// File: rtl/psram_acq_writer.sv
// Acquisition-side sequencer for the QPI PSRAM driver. It drains the sample FIFO as page-bounded
// burst writes, then serves single-word readback requests through the same driver port.
module psram_acq_writer #(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int unsigned MAX_WORDS  = 4194304,
  parameter int unsigned PAGE_BYTES = 1024
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        qpi_on,
  input  logic        acq_start,
  input  logic        acq_stop,
  input  logic        fifo_empty,
  input  logic        write_ended,
  input  logic        endcommand,
  input  logic [15:0] psram_data,
  input  logic        rd_req,
  input  logic [21:0] rd_index,
  output logic [22:0] address,
  output logic [1:0]  read_write,
  output logic        quad_start,
  output logic        burst_mode,
  output logic        stop_acquisition,
  output logic [22:0] words_written,
  output logic        busy,
  output logic        acq_done,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err
);

  localparam int unsigned   AW        = 23;
  localparam logic [AW-1:0] MAX_W     = AW'(MAX_WORDS);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);
  localparam logic [AW-1:0] PAGE_LAST = AW'(PAGE_BYTES - 2);
  localparam logic [1:0]    RW_IDLE   = 2'd0;
  localparam logic [1:0]    RW_WRITE  = 2'd1;
  localparam logic [1:0]    RW_READ   = 2'd2;

  typedef enum logic [2:0] {
    IDLE, READY, WR_WAIT, WR_ISSUE, WR_BUSY, DONE, RD_ISSUE, RD_BUSY
  } state_t;

  state_t        state;
  logic          stop_latch;
  logic [AW-1:0] wr_addr_c;
  logic [AW-1:0] rd_addr_c;
  logic          last_in_page_c;
  logic          last_word_c;
  logic          stop_req_c;
  logic          rd_in_range_c;

  // Byte address of the word about to be written; also the restart address after a burst break.
  assign wr_addr_c      = BASE_ADDR + {words_written[AW-2:0], 1'b0};
  assign rd_addr_c      = BASE_ADDR + {rd_index, 1'b0};
  assign last_in_page_c = (wr_addr_c & PAGE_MASK) == PAGE_LAST;
  assign last_word_c    = (words_written + AW'(1)) == MAX_W;
  assign stop_req_c     = stop_latch | acq_stop;
  assign rd_in_range_c  = {1'b0, rd_index} < words_written;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      stop_latch       <= 1'b0;
      address          <= '0;
      read_write       <= RW_IDLE;
      quad_start       <= 1'b0;
      burst_mode       <= 1'b0;
      stop_acquisition <= 1'b0;
      words_written    <= '0;
      busy             <= 1'b0;
      acq_done         <= 1'b0;
      rd_data          <= '0;
      rd_valid         <= 1'b0;
      rd_err           <= 1'b0;
    end else begin
      quad_start <= 1'b0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;

      if ((state inside {WR_WAIT, WR_ISSUE, WR_BUSY}) && acq_stop)
        stop_latch <= 1'b1;

      case (state)
        IDLE: begin
          if (qpi_on)
            state <= READY;
        end

        // acq_start has priority over a simultaneous readback request.
        READY, DONE: begin
          if (acq_start) begin
            words_written <= '0;
            acq_done      <= 1'b0;
            busy          <= 1'b1;
            state         <= WR_WAIT;
          end else if (state == DONE && rd_req) begin
            if (rd_in_range_c) begin
              address    <= rd_addr_c;
              read_write <= RW_READ;
              burst_mode <= 1'b0;
              quad_start <= 1'b1;
              busy       <= 1'b1;
              state      <= RD_ISSUE;
            end else begin
              rd_err <= 1'b1;
            end
          end
        end

        WR_WAIT: begin
          if (stop_req_c || words_written == MAX_W) begin
            acq_done   <= 1'b1;
            read_write <= RW_IDLE;
            burst_mode <= 1'b0;
            busy       <= 1'b0;
            stop_latch <= 1'b0;
            state      <= DONE;
          end else if (!fifo_empty) begin
            address    <= wr_addr_c;
            read_write <= RW_WRITE;
            burst_mode <= 1'b1;
            quad_start <= 1'b1;
            state      <= WR_ISSUE;
          end
        end

        WR_ISSUE: state <= WR_BUSY;

        // Flag the driver to end the burst after a page-final, capture-final or stopped word.
        WR_BUSY: begin
          if (write_ended) begin
            words_written <= words_written + AW'(1);
            if (last_in_page_c || last_word_c || stop_req_c)
              stop_acquisition <= 1'b1;
          end
          if (endcommand) begin
            stop_acquisition <= 1'b0;
            state            <= WR_WAIT;
          end
        end

        RD_ISSUE: state <= RD_BUSY;

        RD_BUSY: begin
          if (endcommand) begin
            rd_data    <= psram_data;
            rd_valid   <= 1'b1;
            read_write <= RW_IDLE;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_acq_writer.sv
// Bench for psram_acq_writer: two instances (8-word and 600-word capture) share one behavioural
// PSRAM driver model selected by 'sel'; command issues and readback data go through scoreboards.
module tb_psram_acq_writer;

  typedef struct {
    logic [22:0] addr;
    logic [1:0]  rw;
    logic        burst;
  } issue_t;

  logic        mem_clk, rst_n, qpi_on, sel;
  logic        acq_start, acq_stop, write_ended, endcommand, rd_req;
  logic [15:0] psram_data;
  logic [21:0] rd_index;
  logic        fifo_empty;
  int          fifo_cnt;

  logic [22:0] a_addr, b_addr, a_ww, b_ww, m_addr, m_ww;
  logic [1:0]  a_rw, b_rw, m_rw;
  logic        a_qs, b_qs, a_burst, b_burst, a_stop, b_stop, a_busy, b_busy;
  logic        a_done, b_done, a_rdv, b_rdv, a_rderr, b_rderr;
  logic [15:0] a_rdd, b_rdd, m_rdd;
  logic        m_qs, m_burst, m_stop, m_busy, m_done, m_rdv, m_rderr;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rdv_cnt = 0;
  int stop_at = -1;
  issue_t      q_issue[$];
  logic [15:0] q_rd[$];
  int          bursts[$];
  logic [15:0] mem[int];

  assign fifo_empty = (fifo_cnt == 0);

  psram_acq_writer #(.BASE_ADDR(23'h0), .MAX_WORDS(8), .PAGE_BYTES(1024)) dut_a (
    .mem_clk(mem_clk), .rst_n(rst_n), .qpi_on(qpi_on),
    .acq_start(acq_start & ~sel), .acq_stop(acq_stop & ~sel), .fifo_empty(fifo_empty),
    .write_ended(write_ended & ~sel), .endcommand(endcommand & ~sel), .psram_data(psram_data),
    .rd_req(rd_req & ~sel), .rd_index(rd_index),
    .address(a_addr), .read_write(a_rw), .quad_start(a_qs), .burst_mode(a_burst),
    .stop_acquisition(a_stop), .words_written(a_ww), .busy(a_busy), .acq_done(a_done),
    .rd_data(a_rdd), .rd_valid(a_rdv), .rd_err(a_rderr)
  );

  psram_acq_writer #(.BASE_ADDR(23'h0), .MAX_WORDS(600), .PAGE_BYTES(1024)) dut_b (
    .mem_clk(mem_clk), .rst_n(rst_n), .qpi_on(qpi_on),
    .acq_start(acq_start & sel), .acq_stop(acq_stop & sel), .fifo_empty(fifo_empty),
    .write_ended(write_ended & sel), .endcommand(endcommand & sel), .psram_data(psram_data),
    .rd_req(rd_req & sel), .rd_index(rd_index),
    .address(b_addr), .read_write(b_rw), .quad_start(b_qs), .burst_mode(b_burst),
    .stop_acquisition(b_stop), .words_written(b_ww), .busy(b_busy), .acq_done(b_done),
    .rd_data(b_rdd), .rd_valid(b_rdv), .rd_err(b_rderr)
  );

  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_rw    = sel ? b_rw    : a_rw;
  assign m_qs    = sel ? b_qs    : a_qs;
  assign m_burst = sel ? b_burst : a_burst;
  assign m_stop  = sel ? b_stop  : a_stop;
  assign m_ww    = sel ? b_ww    : a_ww;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_rdd   = sel ? b_rdd   : a_rdd;
  assign m_rdv   = sel ? b_rdv   : a_rdv;
  assign m_rderr = sel ? b_rderr : a_rderr;

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input int i);
    return 16'h5A00 ^ 16'(i * 7);
  endfunction

  // Behavioural driver: write bursts continue while the FIFO has data and stop_acquisition is low.
  initial begin
    logic [22:0] a;
    int n;
    bit fin;
    forever begin
      @(negedge mem_clk);
      if (m_qs) begin
        a = m_addr;
        if (m_rw == 2'd1) begin
          n = 0;
          fin = 1'b0;
          while (!fin) begin
            if (fifo_cnt == 0) fin = 1'b1;
            else begin
              @(negedge mem_clk);
              write_ended = 1'b1;
              mem[int'(a)] = pattern(int'(a >> 1));
              fifo_cnt--;
              n++;
              wr_cnt++;
              if (int'(a >> 1) == stop_at) acq_stop = 1'b1;
              @(negedge mem_clk);
              write_ended = 1'b0;
              acq_stop = 1'b0;
              @(negedge mem_clk);
              if (m_stop) fin = 1'b1;
              else a = a + 23'd2;
            end
          end
          bursts.push_back(n);
          endcommand = 1'b1;
          @(negedge mem_clk);
          endcommand = 1'b0;
        end else if (m_rw == 2'd2) begin
          repeat (2) @(negedge mem_clk);
          psram_data = mem.exists(int'(a)) ? mem[int'(a)] : 16'hDEAD;
          endcommand = 1'b1;
          @(negedge mem_clk);
          endcommand = 1'b0;
        end
      end
    end
  end

  always @(negedge mem_clk) begin
    if (m_qs) begin
      if (q_issue.size() == 0) check("unexpected_quad_start", {9'd0, m_addr}, 32'hFFFF_FFFF);
      else begin
        issue_t e;
        e = q_issue.pop_front();
        check("issue_addr", {9'd0, m_addr}, {9'd0, e.addr});
        check("issue_rw", {30'd0, m_rw}, {30'd0, e.rw});
        check("issue_burst", {31'd0, m_burst}, {31'd0, e.burst});
      end
    end
    if (m_rdv) begin
      rdv_cnt++;
      if (q_rd.size() == 0) check("unexpected_rd_valid", {16'd0, m_rdd}, 32'hFFFF_FFFF);
      else check("rd_data", {16'd0, m_rdd}, {16'd0, q_rd.pop_front()});
    end
  end

  task automatic pulse_start();
    acq_start = 1'b1;
    @(negedge mem_clk);
    acq_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!m_done && k < budget) begin
      @(negedge mem_clk);
      k++;
    end
    check(tag, {31'd0, m_done}, 32'd1);
  endtask

  task automatic check_bursts(input string tag, input int l0, input int l1, input int cnt);
    check({tag, "_count"}, bursts.size(), cnt);
    if (bursts.size() > 0) check({tag, "_len0"}, bursts[0], l0);
    if (cnt > 1 && bursts.size() > 1) check({tag, "_len1"}, bursts[1], l1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    rst_n = 1'b0; qpi_on = 1'b0; sel = 1'b0;
    acq_start = 1'b0; acq_stop = 1'b0; write_ended = 1'b0; endcommand = 1'b0;
    rd_req = 1'b0; rd_index = '0; psram_data = '0; fifo_cnt = 0;
    repeat (3) @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge mem_clk);
    check("reset_outs", {a_addr, a_rw, a_qs, a_burst, a_stop, a_busy, a_done, a_rdv, a_rderr}, 32'd0);
    check("reset_ww", {9'd0, a_ww}, 32'd0);
    check("reset_rd_data", {16'd0, a_rdd}, 32'd0);
    qpi_on = 1'b1;
    repeat (2) @(negedge mem_clk);
    check("ready_busy", {31'd0, a_busy}, 32'd0);

    // 8-word capture ending at MAX_WORDS
    fifo_cnt = 8;
    q_issue.push_back('{23'h0, 2'd1, 1'b1});
    pulse_start();
    check("cap8_busy", {31'd0, m_busy}, 32'd1);
    wait_done("cap8_done", 400);
    check("cap8_ww", {9'd0, m_ww}, 32'd8);
    check("cap8_rw_idle", {30'd0, m_rw}, 32'd0);
    check("cap8_burst_off", {31'd0, m_burst}, 32'd0);
    check_bursts("cap8_bursts", 8, 0, 1);
    bursts.delete();
    fifo_cnt = 0;

    // 600-word capture with a page break after word 511
    sel = 1'b1;
    repeat (2) @(negedge mem_clk);
    fifo_cnt = 100000;
    q_issue.push_back('{23'h0, 2'd1, 1'b1});
    q_issue.push_back('{23'h400, 2'd1, 1'b1});
    pulse_start();
    wait_done("cap600_done", 5000);
    check("cap600_ww", {9'd0, m_ww}, 32'd600);
    check_bursts("cap600_bursts", 512, 88, 2);
    bursts.delete();
    fifo_cnt = 0;

    // FIFO runs dry after 3 words, then acq_stop with the 5th word
    fifo_cnt = 3;
    stop_at = 4;
    q_issue.push_back('{23'h0, 2'd1, 1'b1});
    q_issue.push_back('{23'h6, 2'd1, 1'b1});
    pulse_start();
    k = 0;
    while (bursts.size() < 1 && k < 200) begin @(negedge mem_clk); k++; end
    repeat (4) @(negedge mem_clk);
    check("dry_busy", {31'd0, m_busy}, 32'd1);
    check("dry_ww", {9'd0, m_ww}, 32'd3);
    fifo_cnt = 10;
    wait_done("stop_done", 400);
    check("stop_ww", {9'd0, m_ww}, 32'd5);
    check_bursts("stop_bursts", 3, 2, 2);
    bursts.delete();
    stop_at = -1;
    fifo_cnt = 0;

    // readback: in range (2 and the last word 4), then out of range (5)
    for (int i = 2; i <= 4; i += 2) begin
      rd_index = 22'(i);
      q_issue.push_back('{23'(2 * i), 2'd2, 1'b0});
      q_rd.push_back(pattern(i));
      base = rdv_cnt;
      rd_req = 1'b1;
      @(negedge mem_clk);
      rd_req = 1'b0;
      k = 0;
      while (rdv_cnt == base && k < 50) begin @(negedge mem_clk); k++; end
      repeat (3) @(negedge mem_clk);
      check("rd_valid_once", rdv_cnt - base, 1);
      check("rd_done_kept", {31'd0, m_done}, 32'd1);
    end
    rd_index = 22'd5;
    rd_req = 1'b1;
    @(negedge mem_clk);
    rd_req = 1'b0;
    check("rd_err_pulse", {31'd0, m_rderr}, 32'd1);
    @(negedge mem_clk);
    check("rd_err_one_cycle", {31'd0, m_rderr}, 32'd0);
    repeat (4) @(negedge mem_clk);
    check("rd_err_no_valid", rdv_cnt, 2);

    // reset in the middle of a write burst
    sel = 1'b0;
    repeat (2) @(negedge mem_clk);
    fifo_cnt = 4;
    q_issue.push_back('{23'h0, 2'd1, 1'b1});
    base = wr_cnt;
    pulse_start();
    k = 0;
    while (wr_cnt < base + 2 && k < 200) begin @(negedge mem_clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {a_addr, a_rw, a_qs, a_burst, a_stop, a_busy, a_done, a_rdv, a_rderr}, 32'd0);
    check("midrst_ww", {9'd0, a_ww}, 32'd0);
    check("midrst_b_ww", {9'd0, b_ww}, 32'd0);
    k = 0;
    while (bursts.size() < 1 && k < 200) begin @(negedge mem_clk); k++; end
    bursts.delete();
    fifo_cnt = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge mem_clk);
    check("postrst_busy", {31'd0, a_busy}, 32'd0);
    fifo_cnt = 8;
    q_issue.push_back('{23'h0, 2'd1, 1'b1});
    pulse_start();
    wait_done("restart_done", 400);
    check("restart_ww", {9'd0, m_ww}, 32'd8);
    check_bursts("restart_bursts", 8, 0, 1);

    repeat (4) @(negedge mem_clk);
    check("issues_left", q_issue.size(), 0);
    check("reads_left", q_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
